// File: rtl/enemy_base_hit_tracker_pkg.sv
// Shared definitions for the enemy base hit tracker.
// Holds the life-cycle state encoding, sprite/bullet/screen geometry,
// the hit and timing limits, and small helper functions used by the top.
package enemy_base_pkg;

  // Life cycle of the base sprite.
  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_FLASH   = 2'd1,
    ST_EXPLODE = 2'd2,
    ST_DEAD    = 2'd3
  } base_state_e;

  localparam logic [9:0] SPRITE_W       = 10'd64;
  localparam logic [9:0] SPRITE_H       = 10'd72;
  localparam logic [9:0] BULLET_SZ      = 10'd4;
  localparam logic [2:0] MAX_HITS       = 3'd6;
  localparam logic [4:0] FLASH_FRAMES   = 5'd8;
  localparam logic [4:0] EXPLODE_FRAMES = 5'd16;
  localparam logic [9:0] SCREEN_LAST_X  = 10'd639;
  localparam logic [9:0] SCREEN_LAST_Y  = 10'd479;

  // Frame-counter values seen on the last frame of each timed state.
  localparam logic [3:0] FLASH_LAST   = 4'(FLASH_FRAMES - 5'd1);
  localparam logic [3:0] EXPLODE_LAST = 4'(EXPLODE_FRAMES - 5'd1);

  // The last visible pixel of the raster marks the end of a frame.
  function automatic logic is_frame_end(input logic [9:0] x, input logic [9:0] y);
    return (x == SCREEN_LAST_X) && (y == SCREEN_LAST_Y);
  endfunction

  // Hit counter increment that sticks at the destruction threshold.
  function automatic logic [2:0] hits_sat_inc(input logic [2:0] h);
    return (h >= MAX_HITS) ? MAX_HITS : h + 3'd1;
  endfunction

endpackage

// File: rtl/enemy_base_hit_tracker_if.sv
// Pixel/sprite/bullet bus of the enemy base hit tracker.
// master: the video/game side that drives scan position, sprite data,
//         bullet and respawn, and observes the tracker outputs.
// slave : the tracker itself.
interface enemy_base_hit_tracker_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] Base_X;
  logic [9:0] Base_Y;
  logic [2:0] base_rom;
  logic [9:0] bullet_X;
  logic [9:0] bullet_Y;
  logic       bullet_active;
  logic       respawn;
  logic       collided;
  logic       draw_enable;
  logic [2:0] hits;
  logic       destroyed;
  logic [1:0] explode_frame;

  modport master (
    output DrawX, DrawY, Base_X, Base_Y, base_rom,
    output bullet_X, bullet_Y, bullet_active, respawn,
    input  collided, draw_enable, hits, destroyed, explode_frame
  );

  modport slave (
    input  DrawX, DrawY, Base_X, Base_Y, base_rom,
    input  bullet_X, bullet_Y, bullet_active, respawn,
    output collided, draw_enable, hits, destroyed, explode_frame
  );
endinterface

// File: rtl/enemy_base_hit_tracker_box_contains.sv
// Combinational point-in-rectangle test.
// Ports: i_px/i_py point, i_cx/i_cy rectangle top-left corner,
//        i_w/i_h rectangle size, o_inside high when the point is covered.
// The offsets are 10-bit wrapping differences, so a point left of or above
// the corner wraps to a large offset and is rejected by the same compare.
module box_contains (
  input  logic [9:0] i_px,
  input  logic [9:0] i_py,
  input  logic [9:0] i_cx,
  input  logic [9:0] i_cy,
  input  logic [9:0] i_w,
  input  logic [9:0] i_h,
  output logic       o_inside
);
  logic [9:0] w_dx;
  logic [9:0] w_dy;

  assign w_dx     = i_px - i_cx;
  assign w_dy     = i_py - i_cy;
  assign o_inside = (w_dx < i_w) && (w_dy < i_h);
endmodule

// File: rtl/enemy_base_hit_tracker.sv
// Enemy base hit tracker.
// Watches the scan for pixels where an active player bullet overlaps an
// opaque base sprite pixel, accumulates one hit per frame, and runs the
// base through ALIVE -> FLASH / EXPLODE -> DEAD, updating once per frame.
// Ports: vga_clk pixel clock, reset_n async active-low reset,
//        bus (slave) scan position, sprite, bullet, respawn in;
//        collided, draw_enable, hits, destroyed, explode_frame out.
module enemy_base_hit_tracker
  import enemy_base_pkg::*;
(
  input  logic                      vga_clk,
  input  logic                      reset_n,
  enemy_base_hit_tracker_if.slave   bus
);

  logic        w_in_box;
  logic        w_in_bullet;
  logic        w_pixel_hit;
  logic        w_frame_end;
  logic        w_hit_this_frame;
  logic        w_respawn_now;
  logic [2:0]  w_hits_inc;

  base_state_e w_state_nx;
  logic [3:0]  w_cnt_nx;
  logic [2:0]  w_hits_nx;
  logic        w_collided_nx;
  logic        w_frame_hit_nx;
  logic        w_draw_nx;
  logic [1:0]  w_explode_nx;

  base_state_e r_state;
  logic [3:0]  r_frame_cnt;
  logic [2:0]  r_hits;
  logic        r_collided;
  logic        r_frame_hit;
  logic        r_draw_enable;
  logic        r_destroyed;
  logic [1:0]  r_explode_frame;

  box_contains u_base_box (
    .i_px     (bus.DrawX),
    .i_py     (bus.DrawY),
    .i_cx     (bus.Base_X),
    .i_cy     (bus.Base_Y),
    .i_w      (SPRITE_W),
    .i_h      (SPRITE_H),
    .o_inside (w_in_box)
  );

  box_contains u_bullet_box (
    .i_px     (bus.DrawX),
    .i_py     (bus.DrawY),
    .i_cx     (bus.bullet_X),
    .i_cy     (bus.bullet_Y),
    .i_w      (BULLET_SZ),
    .i_h      (BULLET_SZ),
    .o_inside (w_in_bullet)
  );

  assign w_pixel_hit = w_in_box && w_in_bullet && bus.bullet_active && (bus.base_rom != 3'd0);
  assign w_frame_end = is_frame_end(bus.DrawX, bus.DrawY);
  // A hit on the frame-end pixel itself still belongs to the ending frame.
  assign w_hit_this_frame = r_frame_hit || w_pixel_hit;
  assign w_respawn_now    = (r_state == ST_DEAD) && bus.respawn;
  assign w_hits_inc       = hits_sat_inc(r_hits);

  // Next-state, frame counter, hit count and collision flag.
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_frame_cnt;
    w_hits_nx     = r_hits;
    w_collided_nx = r_collided;
    if (w_respawn_now) begin
      w_state_nx    = ST_ALIVE;
      w_cnt_nx      = 4'd0;
      w_hits_nx     = 3'd0;
      w_collided_nx = 1'b0;
    end else if (w_frame_end) begin
      // collided only survives one frame; it is re-raised below on a new hit.
      w_collided_nx = 1'b0;
      case (r_state)
        ST_ALIVE: begin
          w_cnt_nx = 4'd0;
          if (w_hit_this_frame) begin
            w_hits_nx     = w_hits_inc;
            w_collided_nx = 1'b1;
            if (w_hits_inc == MAX_HITS) begin
              w_state_nx = ST_EXPLODE;
            end else begin
              w_state_nx = ST_FLASH;
            end
          end else begin
            w_state_nx = ST_ALIVE;
          end
        end
        ST_FLASH: begin
          if (r_frame_cnt == FLASH_LAST) begin
            w_state_nx = ST_ALIVE;
            w_cnt_nx   = 4'd0;
          end else begin
            w_cnt_nx = r_frame_cnt + 4'd1;
          end
        end
        ST_EXPLODE: begin
          if (r_frame_cnt == EXPLODE_LAST) begin
            w_state_nx = ST_DEAD;
            w_cnt_nx   = 4'd0;
          end else begin
            w_cnt_nx = r_frame_cnt + 4'd1;
          end
        end
        ST_DEAD: begin
          w_cnt_nx = 4'd0;
        end
        default: begin
          w_state_nx = ST_ALIVE;
          w_cnt_nx   = 4'd0;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // Sticky per-frame hit flag: cleared at frame end and on revival.
  always_comb begin
    w_frame_hit_nx = r_frame_hit;
    if (w_respawn_now || w_frame_end) begin
      w_frame_hit_nx = 1'b0;
    end else if (w_pixel_hit) begin
      w_frame_hit_nx = 1'b1;
    end else begin
      w_frame_hit_nx = r_frame_hit;
    end
  end

  // Output values derived from the next state so they register together with it.
  always_comb begin
    w_draw_nx    = 1'b0;
    w_explode_nx = 2'd0;
    case (w_state_nx)
      ST_ALIVE:   w_draw_nx = 1'b1;
      ST_FLASH:   w_draw_nx = ~w_cnt_nx[1];
      ST_EXPLODE: w_explode_nx = w_cnt_nx[3:2];
      ST_DEAD:    w_draw_nx = 1'b0;
      default:    w_draw_nx = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_ALIVE;
      r_frame_cnt     <= 4'd0;
      r_hits          <= 3'd0;
      r_collided      <= 1'b0;
      r_frame_hit     <= 1'b0;
      r_draw_enable   <= 1'b1;
      r_destroyed     <= 1'b0;
      r_explode_frame <= 2'd0;
    end else begin
      r_state         <= w_state_nx;
      r_frame_cnt     <= w_cnt_nx;
      r_hits          <= w_hits_nx;
      r_collided      <= w_collided_nx;
      r_frame_hit     <= w_frame_hit_nx;
      r_draw_enable   <= w_draw_nx;
      r_destroyed     <= (w_state_nx == ST_DEAD);
      r_explode_frame <= w_explode_nx;
    end
  end

  assign bus.collided      = r_collided;
  assign bus.draw_enable   = r_draw_enable;
  assign bus.hits          = r_hits;
  assign bus.destroyed     = r_destroyed;
  assign bus.explode_frame = r_explode_frame;

endmodule

// File: tb/tb_enemy_base_hit_tracker.sv
// Self-checking bench for enemy_base_hit_tracker.
// Frames are compressed: a few scan pixels followed by the (639,479) pixel.
// The reference model tracks hit count and the frame age since the last
// counted hit, and derives visibility/explosion outputs arithmetically.
module tb_enemy_base_hit_tracker;
  logic vga_clk = 1'b0;
  logic reset_n;

  enemy_base_hit_tracker_if bus ();

  enemy_base_hit_tracker dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_errors = 0;

  localparam int P_ALIVE = 0, P_FLASH = 1, P_EXPLODE = 2, P_DEAD = 3;

  // Reference model state.
  int m_hits      = 0;
  int m_frame_no  = 0;
  int m_last_hit  = 0;
  bit m_frame_hit = 1'b0;
  bit m_collided  = 1'b0;

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int d10(input int a, input int b);
    return ((a - b) % 1024 + 1024) % 1024;
  endfunction

  function automatic int m_age();
    return m_frame_no - m_last_hit;
  endfunction

  function automatic int m_phase();
    if (m_hits == 0) return P_ALIVE;
    if (m_hits >= 6) return (m_age() < 16) ? P_EXPLODE : P_DEAD;
    return (m_age() < 8) ? P_FLASH : P_ALIVE;
  endfunction

  task automatic model_reset();
    m_hits      = 0;
    m_frame_hit = 1'b0;
    m_collided  = 1'b0;
    m_last_hit  = m_frame_no;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int  x, y;
    bit  pix, fend;
    int  ph;
    x    = int'(bus.DrawX);
    y    = int'(bus.DrawY);
    pix  = (d10(x, int'(bus.Base_X)) < 64) && (d10(y, int'(bus.Base_Y)) < 72) &&
           (d10(x, int'(bus.bullet_X)) < 4) && (d10(y, int'(bus.bullet_Y)) < 4) &&
           bus.bullet_active && (bus.base_rom != 3'd0);
    fend = (x == 639) && (y == 479);
    ph   = m_phase();
    if (ph == P_DEAD && bus.respawn) begin
      m_hits      = 0;
      m_frame_hit = 1'b0;
    end else if (fend) begin
      m_frame_no++;
      if (ph == P_ALIVE && (m_frame_hit || pix)) begin
        m_hits++;
        m_last_hit = m_frame_no;
        m_collided = 1'b1;
      end else begin
        m_collided = 1'b0;
      end
      m_frame_hit = 1'b0;
    end else if (pix) begin
      m_frame_hit = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int ph;
    ph = m_phase();
    chk_eq("hits", 16'(bus.hits), 16'(m_hits));
    chk_eq("collided", 16'(bus.collided), 16'(m_collided));
    chk_eq("destroyed", 16'(bus.destroyed), 16'(ph == P_DEAD));
    chk_eq("draw_enable", 16'(bus.draw_enable),
           16'((ph == P_ALIVE) || (ph == P_FLASH && ((m_age() / 2) % 2) == 0)));
    chk_eq("explode_frame", 16'(bus.explode_frame), 16'((ph == P_EXPLODE) ? m_age() / 4 : 0));
  endtask

  task automatic drive(input int x, input int y, input int bx, input int by,
                       input int ux, input int uy, input int rom, input bit act,
                       input bit resp);
    bus.DrawX         = 10'(x);
    bus.DrawY         = 10'(y);
    bus.Base_X        = 10'(bx);
    bus.Base_Y        = 10'(by);
    bus.bullet_X      = 10'(ux);
    bus.bullet_Y      = 10'(uy);
    bus.base_rom      = 3'(rom);
    bus.bullet_active = act;
    bus.respawn       = resp;
    @(posedge vga_clk);
    model_step();
    #1;
    check_outputs();
  endtask

  // Drive one pixel that is covered by both sprite box and bullet box.
  task automatic drive_targeted(input int px, input int py, input int rom, input bit act);
    int bx, by, ux, uy;
    bx = d10(px, $urandom_range(0, 63));
    by = d10(py, $urandom_range(0, 71));
    ux = d10(px, $urandom_range(0, 3));
    uy = d10(py, $urandom_range(0, 3));
    drive(px, py, bx, by, ux, uy, rom, act, 1'b0);
  endtask

  task automatic rand_frame();
    for (int k = 0; k < 3; k++) begin
      if (k == 0 && $urandom_range(0, 9) == 0) begin
        drive($urandom_range(0, 638), $urandom_range(0, 479), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
              0, 1'b1, 1'b1);
      end else if ($urandom_range(0, 3) == 0) begin
        drive_targeted($urandom_range(0, 638), $urandom_range(0, 479),
                       $urandom_range(0, 7), $urandom_range(0, 7) != 0);
      end else begin
        drive($urandom_range(0, 638), $urandom_range(0, 479), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 7), $urandom_range(0, 1), 1'b0);
      end
    end
    if ($urandom_range(0, 3) == 0) begin
      drive_targeted(639, 479, $urandom_range(1, 7), 1'b1);
    end else begin
      drive(639, 479, $urandom_range(0, 1023), $urandom_range(0, 1023),
            $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 7),
            1'b1, 1'b0);
    end
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.DrawX         = 10'd0;
    bus.DrawY         = 10'd0;
    bus.Base_X        = 10'd200;
    bus.Base_Y        = 10'd100;
    bus.bullet_X      = 10'd230;
    bus.bullet_Y      = 10'd130;
    bus.base_rom      = 3'd0;
    bus.bullet_active = 1'b0;
    bus.respawn       = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1;
    check_outputs();
    chk_eq("reset_draw", 16'(bus.draw_enable), 16'd1);
    @(negedge vga_clk);
    reset_n = 1'b1;

    // Opaque base at (200,100), bullet inside for one frame, then 10 quiet frames.
    drive(231, 131, 200, 100, 230, 130, 3, 1'b1, 1'b0);
    drive(639, 479, 200, 100, 230, 130, 3, 1'b1, 1'b0);
    chk_eq("first_hit", 16'(bus.hits), 16'd1);
    chk_eq("first_collided", 16'(bus.collided), 16'd1);
    for (int f = 0; f < 10; f++) begin
      drive(232, 132, 200, 100, 230, 130, 3, 1'b0, 1'b0);
      drive(639, 479, 200, 100, 230, 130, 3, 1'b0, 1'b0);
    end
    chk_eq("after_flash_hits", 16'(bus.hits), 16'd1);

    // Transparent pixels under the bullet never count.
    drive(231, 131, 200, 100, 230, 130, 0, 1'b1, 1'b0);
    drive(639, 479, 200, 100, 230, 130, 0, 1'b1, 1'b0);
    chk_eq("transparent_hits", 16'(bus.hits), 16'd1);

    // Wrap-around: base near the bottom-right corner, bullet at (2,3).
    drive(2, 3, 600, 450, 2, 3, 5, 1'b1, 1'b0);
    drive(639, 479, 600, 450, 2, 3, 5, 1'b1, 1'b0);
    chk_eq("wrap_no_hit", 16'(bus.hits), 16'd1);
    drive(637, 477, 600, 450, 636, 476, 5, 1'b1, 1'b0);
    drive(639, 479, 600, 450, 636, 476, 5, 1'b1, 1'b0);
    chk_eq("wrap_hit", 16'(bus.hits), 16'd2);

    // Reset mid-frame with the sticky hit flag set: the partial frame is discarded.
    for (int f = 0; f < 9; f++) rand_frame();
    drive(231, 131, 200, 100, 230, 130, 3, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge vga_clk);
    reset_n = 1'b1;
    drive(639, 479, 0, 0, 900, 900, 0, 1'b0, 1'b0);
    chk_eq("reset_discard_hits", 16'(bus.hits), 16'd0);
    chk_eq("reset_discard_coll", 16'(bus.collided), 16'd0);

    for (int f = 0; f < 400; f++) rand_frame();

    // Hit on every frame-end pixel until the base is destroyed.
    for (int f = 0; f < 150 && m_phase() != P_DEAD; f++) begin
      drive(639, 479, 629, 470, 638, 478, 3, 1'b1, 1'b0);
    end
    chk_eq("reach_dead", 16'(bus.destroyed), 16'd1);
    chk_eq("dead_hits", 16'(bus.hits), 16'd6);
    drive(10, 10, 0, 0, 900, 900, 0, 1'b0, 1'b1);
    chk_eq("respawn_hits", 16'(bus.hits), 16'd0);
    chk_eq("respawn_draw", 16'(bus.draw_enable), 16'd1);
    chk_eq("respawn_destroyed", 16'(bus.destroyed), 16'd0);
    for (int f = 0; f < 20; f++) rand_frame();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
